// File: rtl/cordic_pkg.sv
// Shared types and defaults for the cordic arbiter slice.
// Holds the FSM state encoding and the default datapath width and timeout.
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int W_DEF       = 16;
    localparam int TIMEOUT_DEF = 20;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Client-side and core-side signals of the cordic arbiter.
// The master modport is the environment (clients + core); slave is the arbiter.
interface cordic_arbiter_if
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = W_DEF
) ();
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] theta_in;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   rsp_vld;
    logic [W-1:0]       rsp_cos;
    logic               rsp_err;
    logic               busy;
    logic               cord_bgn;
    logic [W-1:0]       cord_theta;
    logic [W-1:0]       cord_cos;
    logic               cord_fin;

    modport master (
        output req, theta_in, cord_cos, cord_fin,
        input  ack, rsp_vld, rsp_cos, rsp_err, busy, cord_bgn, cord_theta
    );

    modport slave (
        input  req, theta_in, cord_cos, cord_fin,
        output ack, rsp_vld, rsp_cos, rsp_err, busy, cord_bgn, cord_theta
    );
endinterface

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last owner,
// wrapping around; o_any flags that at least one request is present.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int LW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [LW-1:0]    i_last,
    output logic [LW-1:0]    o_grant,
    output logic             o_any
);
    logic [LW-1:0] w_idx;

    // Scan from farthest to nearest so the nearest candidate after i_last wins.
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = LW'((int'(i_last) + 1 + k) % N_REQ);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
                o_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic core among N_REQ clients, one transaction at a time,
// with round-robin grant and a WAIT timeout that reports an error response.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic             clk,
    input logic             rst_b,
    cordic_arbiter_if.slave bus
);
    localparam int LW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t           r_state, w_state_nxt;
    logic [LW-1:0]    r_owner, r_last, w_grant;
    logic             w_any;
    logic [CW-1:0]    r_cnt;
    logic             w_timeout;
    logic [N_REQ-1:0] r_ack, r_rsp_vld;
    logic             r_rsp_err, r_cord_bgn;
    logic [W-1:0]     r_rsp_cos, r_cord_theta;

    rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst_b) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.cord_fin || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pulsed outputs are loaded on the edge entering the state they belong to.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_owner      <= '0;
            r_last       <= LW'(N_REQ - 1);
            r_cnt        <= '0;
            r_ack        <= '0;
            r_rsp_vld    <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_cos    <= '0;
            r_cord_bgn   <= 1'b0;
            r_cord_theta <= '0;
        end else begin
            r_ack      <= '0;
            r_rsp_vld  <= '0;
            r_cord_bgn <= 1'b0;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_owner      <= w_grant;
                    r_cord_theta <= bus.theta_in[w_grant*W +: W];
                    r_ack        <= N_REQ'(1) << w_grant;
                    r_cord_bgn   <= 1'b1;
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // fin takes priority over a coinciding timeout
                    if (bus.cord_fin) begin
                        r_rsp_cos <= bus.cord_cos;
                        r_rsp_err <= 1'b0;
                        r_rsp_vld <= N_REQ'(1) << r_owner;
                    end else if (w_timeout) begin
                        r_rsp_cos <= '0;
                        r_rsp_err <= 1'b1;
                        r_rsp_vld <= N_REQ'(1) << r_owner;
                    end
                end
                S_RESP: r_last <= r_owner;
                default: ;
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.rsp_vld    = r_rsp_vld;
    assign bus.rsp_cos    = r_rsp_cos;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.cord_bgn   = r_cord_bgn;
    assign bus.cord_theta = r_cord_theta;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: single request, round robin, timeout,
// fin/timeout collision, dropped request and reset in the middle of WAIT.
module tb_cordic_arbiter;
    localparam int N_REQ   = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 20;

    logic clk;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    cordic_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

    cordic_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"},  32'(bus.ack), 32'h0);
        chk({tag, "_vld"},  32'(bus.rsp_vld), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_bgn"},  32'(bus.cord_bgn), 32'h0);
    endtask

    // Called at a negedge in IDLE with req set so the next edge grants `own`.
    // fin_at = WAIT cycle (1-based) in which fin is driven, 0 = never.
    task automatic txn(input string tag, input int own, input logic [15:0] th,
                       input int fin_at, input logic [15:0] cos, input bit drop,
                       input int pulse_k, input bit exp_err, input logic [15:0] exp_cos);
        int nw;
        bit quiet;
        nw = (fin_at >= 1 && fin_at <= TIMEOUT) ? fin_at : TIMEOUT;
        @(negedge clk);
        chk({tag, "_ack"},   32'(bus.ack), 32'(1) << own);
        chk({tag, "_bgn"},   32'(bus.cord_bgn), 32'h1);
        chk({tag, "_theta"}, 32'(bus.cord_theta), 32'(th));
        if (drop) bus.req = '0;
        bus.cord_cos = cos;
        quiet = 1'b1;
        for (int k = 1; k <= nw; k++) begin
            @(negedge clk);
            if (bus.ack != 0 || bus.cord_bgn || bus.rsp_vld != 0 || !bus.busy ||
                bus.cord_theta != th) quiet = 1'b0;
            if (pulse_k > 0 && k == pulse_k)     bus.req[3] = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) bus.req[3] = 1'b0;
            bus.cord_fin = (k == fin_at);
        end
        @(negedge clk);
        bus.cord_fin = 1'b0;
        chk({tag, "_wait_quiet"}, 32'(quiet), 32'h1);
        chk({tag, "_rsp_vld"},    32'(bus.rsp_vld), 32'(1) << own);
        chk({tag, "_rsp_err"},    32'(bus.rsp_err), 32'(exp_err));
        chk({tag, "_rsp_cos"},    32'(bus.rsp_cos), 32'(exp_cos));
        @(negedge clk);
        chk({tag, "_idle_vld"},   32'(bus.rsp_vld), 32'h0);
        chk({tag, "_idle_busy"},  32'(bus.busy), 32'h0);
    endtask

    initial begin
        rst_b        = 1'b1;
        bus.req      = '0;
        bus.theta_in = {16'h4000, 16'h0000, 16'h2000, 16'h1000};
        bus.cord_cos = '0;
        bus.cord_fin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_err",   32'(bus.rsp_err), 32'h0);
        chk("reset_cos",   32'(bus.rsp_cos), 32'h0);
        chk("reset_theta", 32'(bus.cord_theta), 32'h0);
        rst_b = 1'b0;

        // Single request from client 2, fin 18 cycles after bgn
        bus.req = 4'b0100;
        txn("single", 2, 16'h0000, 18, 16'h4000, 1'b1, 0, 1'b0, 16'h4000);

        // Round robin with all requests held from reset
        bus.req = 4'b1111;
        rst_b   = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        txn("rr0", 0, 16'h1000, 3, 16'h0100, 1'b0, 0, 1'b0, 16'h0100);
        txn("rr1", 1, 16'h2000, 3, 16'h0101, 1'b0, 0, 1'b0, 16'h0101);
        txn("rr2", 2, 16'h0000, 3, 16'h0102, 1'b0, 0, 1'b0, 16'h0102);
        txn("rr3", 3, 16'h4000, 3, 16'h0103, 1'b0, 0, 1'b0, 16'h0103);
        txn("rr4", 0, 16'h1000, 3, 16'h0104, 1'b1, 0, 1'b0, 16'h0104);

        // Timeout: fin never arrives
        bus.req = 4'b0010;
        txn("tmo", 1, 16'h2000, 0, 16'hBEEF, 1'b1, 0, 1'b1, 16'h0000);

        // fin on the last WAIT cycle beats the timeout
        bus.req = 4'b1000;
        txn("coll", 3, 16'h4000, TIMEOUT, 16'h1234, 1'b1, 0, 1'b0, 16'h1234);

        // req[3] pulsed for one cycle while busy is lost
        bus.req = 4'b0001;
        txn("drop", 0, 16'h1000, 4, 16'h0055, 1'b1, 2, 1'b0, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("drop_after");
        end

        // Reset in the middle of WAIT abandons the transaction
        bus.req = 4'b0100;
        @(negedge clk);
        chk("rst_mid_ack", 32'(bus.ack), 32'h4);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk_quiet("rst_mid");
        chk("rst_mid_theta", 32'(bus.cord_theta), 32'h0);
        chk("rst_mid_cos",   32'(bus.rsp_cos), 32'h0);
        chk("rst_mid_err",   32'(bus.rsp_err), 32'h0);
        bus.cord_cos = 16'h5555;
        bus.cord_fin = 1'b1;
        @(negedge clk);
        bus.cord_fin = 1'b0;
        chk_quiet("late_fin");
        @(negedge clk);
        chk_quiet("late_fin2");
        bus.req = 4'b1010;
        txn("post_rst", 1, 16'h2000, 3, 16'h0777, 1'b1, 0, 1'b0, 16'h0777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
